memory_fsm_fib_checker: RTL and testbench
=========================================

// Module: memory_fsm_fib_checker
// PURPOSE
//  Read-back verifier for the dual-port fib memory image. After the writer FSM fills segments
//  0..LAST_SEG, this block sweeps the same addresses on both ports and compares each word
//  against the written pattern. It reports the error count, the first failing segment/port,
//  and pass/done flags for board LEDs/7-seg. It never writes memory.
// PARAMETERS
//  ADDR_W   15       memory address width; addr = {seg, OFF_W offset bits}
//  DATA_W   16       memory data width
//  SEG_W    5        segment index width; OFF_W = ADDR_W - SEG_W = 10
//  LAST_SEG 30       last segment checked (the writer leaves segment 31 unwritten)
//  PAT0     4'b1010  low nibble of port-0 word; expected q0 = zero-ext {seg, PAT0}
//  PAT1     4'b1110  low nibble of port-1 word; expected q1 = zero-ext {seg, PAT1}
// PORTS
//  clk       in   1       clock; everything updates on the rising edge
//  clr       in   1       synchronous active-high reset
//  start     in   1       starts a sweep when sampled in IDLE or DONE
//  q0        in   DATA_W  port-0 read data; 1-cycle latency after addr0
//  q1        in   DATA_W  port-1 read data; 1-cycle latency after addr1
//  addr0     out  ADDR_W  port-0 address {seg, all-0 offset}
//  addr1     out  ADDR_W  port-1 address {seg, all-1 offset}
//  w0, w1    out  1       write enables; constant 0
//  busy      out  1       sweep in progress (READ or DRAIN)
//  done      out  1       sweep finished; held until the next start or clr
//  pass      out  1       done && err_count==0
//  err_count out  6       mismatches this sweep; saturates at 6'h3F
//  fail_seg  out  SEG_W   segment of the first mismatch; 0 if none
//  fail_port out  1       port of the first mismatch; 0 = port 0
// BEHAVIOUR
//  - Reset (clr=1 at an edge, any state, including mid-sweep):
//    state=IDLE, seg=0, cmp_valid=0, addr0=addr1=0, busy=done=pass=0, err_count=0,
//    fail_seg=0, fail_port=0. An in-flight compare is discarded.
//  - IDLE: addrs = 0. If start=1 -> READ, seg=0, and clear err_count/fail_* and first_seen.
//  - READ: drive addr0={seg,10'h000} and addr1={seg,10'h3FF} from registered seg.
//    Each edge: cmp_valid<=1, cmp_seg<=seg.
//    If seg==LAST_SEG -> DRAIN; else seg<=seg+1.
//  - DRAIN: addrs hold the last segment. Compare the last returned data; cmp_valid<=0 -> DONE.
//  - DONE: done=1 and pass valid. start=1 -> restart the sweep (done drops the next cycle).
//  - Compare stage: active whenever cmp_valid=1, on q0/q1 that cycle against
//    exp0={{DATA_W-SEG_W-4{1'b0}},cmp_seg,PAT0} and exp1 (same with PAT1).
//    Each mismatching port adds 1; both mismatching in one cycle add 2; saturate at 63.
//  - First mismatch latches fail_seg/fail_port only while first_seen=0.
//    If both ports fail in the same cycle, port 0 wins.
//  - Latency: start sampled at edge k -> READ for LAST_SEG+1 cycles -> DRAIN 1 cycle.
//    done=1 from edge k+LAST_SEG+3 (33 cycles at default).
//  - start while busy is ignored. start and clr together: clr wins.
//  - seg never wraps: it stops at LAST_SEG; no address beyond {LAST_SEG, 10'h3FF} is issued.
// STRUCTURE
//  - Shared include mem_fib_defs.vh holds ADDR_W/DATA_W/SEG_W, PAT0/PAT1, LAST_SEG
//    (common with the writer FSM) and the state encodings IDLE/READ/DRAIN/DONE.
//  - One sub-module: mem_fib_word_cmp. Combinational expected-word build plus compare,
//    one instance per port, outputs mismatch.
//  - Top holds the FSM, seg counter, compare pipeline register, and error/first-fail capture.
// TESTING
//  - Memory model preloaded with the writer image; 1-cycle start -> done at +33 cycles,
//    pass=1, err_count=0. During the sweep, seg 3 shows addr0=15'h0C00, addr1=15'h0FFF.
//  - Seg 7 port1 corrupted 16'h007E->16'h007F -> err_count=1, fail_seg=7, fail_port=1, pass=0.
//  - Seg 0 both ports and seg 30 port0 corrupted -> err_count=3, fail_seg=0, fail_port=0.
//  - All-zero memory -> err_count=62, fail_seg=0, fail_port=0, pass=0.
//  - clr asserted 10 cycles into a sweep -> next cycle busy=0, addr0=0, err_count=0.
//    A new start then yields a full 33-cycle sweep with correct results.
//  - start pulsed while busy -> no effect on timing. start=1 in DONE -> done=0 next cycle,
//    new sweep, and err_count restarts from 0.

Source files
------------

// File: rtl/memory_fsm_fib_checker_pkg.sv
// Shared constants, state encoding and expected-word helper for the fib memory
// read-back checker.
package memory_fsm_fib_checker_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int SEG_W  = 5;
  localparam int OFF_W  = ADDR_W - SEG_W;
  localparam int ERR_W  = 6;

  localparam logic [SEG_W-1:0] LAST_SEG = 5'd30;
  localparam logic [3:0]       PAT0     = 4'b1010;
  localparam logic [3:0]       PAT1     = 4'b1110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Word the writer FSM leaves at a segment: zero-extended {seg, pattern nibble}.
  function automatic logic [DATA_W-1:0] exp_word(input logic [SEG_W-1:0] seg,
                                                 input logic [3:0]       pat);
    return {{(DATA_W-SEG_W-4){1'b0}}, seg, pat};
  endfunction

endpackage

// File: rtl/memory_fsm_fib_checker_if.sv
// Dual-port memory bus between the checker (master) and the fib memory (slave).
interface memory_fsm_fib_checker_if;
  import memory_fsm_fib_checker_pkg::*;

  // Read data on q0/q1 corresponds to the addresses presented one cycle earlier.
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] q0;
  logic [DATA_W-1:0] q1;
  logic              w0;
  logic              w1;

  modport master (output addr0, output addr1, output w0, output w1,
                  input  q0,    input  q1);
  modport slave  (input  addr0, input  addr1, input  w0, input  w1,
                  output q0,    output q1);

endinterface

// File: rtl/memory_fsm_fib_checker_word_cmp.sv
// Builds the expected word for one port from the segment under compare and
// flags a mismatch against the returned read data.
module memory_fsm_fib_checker_word_cmp
  import memory_fsm_fib_checker_pkg::*;
#(
  parameter logic [3:0] PAT = 4'b0000
) (
  input  logic [SEG_W-1:0]  seg,
  input  logic [DATA_W-1:0] q,
  output logic              mismatch
);

  logic [DATA_W-1:0] expected;

  always_comb begin
    expected = exp_word(seg, PAT);
    mismatch = (q !== expected);
  end

endmodule

// File: rtl/memory_fsm_fib_checker.sv
// Read-back verifier: sweeps segments 0..LAST_SEG on both memory ports, compares
// against the writer pattern and reports error count, first failure and pass/done.
module memory_fsm_fib_checker
  import memory_fsm_fib_checker_pkg::*;
(
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  memory_fsm_fib_checker_if.master mem,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_W-1:0]         err_count,
  output logic [SEG_W-1:0]         fail_seg,
  output logic                     fail_port,
  output state_t                   dbg_state
);

  // start is a level sampled each edge; it is honoured only in IDLE or DONE and
  // ignored while busy. done is a held status, cleared by the next accepted start.

  state_t           state;
  state_t           state_nx;
  logic [SEG_W-1:0] seg;
  logic             cmp_valid;
  logic [SEG_W-1:0] cmp_seg;
  logic             first_seen;
  logic             mis0;
  logic             mis1;
  logic             start_ok;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_next;

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign dbg_state = state;
  assign pass      = done && (err_count == '0);

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)            state_nx = READ;
      READ:    if (seg == LAST_SEG)  state_nx = DRAIN;
      DRAIN:                         state_nx = DONE;
      DONE:    if (start)            state_nx = READ;
      default:                       state_nx = IDLE;
    endcase
  end

  // Output logic: addresses come from the registered segment, never beyond LAST_SEG.
  always_comb begin
    mem.addr0 = '0;
    mem.addr1 = '0;
    mem.w0    = 1'b0;
    mem.w1    = 1'b0;
    busy      = 1'b0;
    case (state)
      READ, DRAIN: begin
        mem.addr0 = {seg, {OFF_W{1'b0}}};
        mem.addr1 = {seg, {OFF_W{1'b1}}};
        busy      = 1'b1;
      end
      DONE: begin
        mem.addr0 = {seg, {OFF_W{1'b0}}};
        mem.addr1 = {seg, {OFF_W{1'b1}}};
      end
      default: ;
    endcase
  end

  memory_fsm_fib_checker_word_cmp #(.PAT(PAT0)) u_cmp0 (
    .seg      (cmp_seg),
    .q        (mem.q0),
    .mismatch (mis0)
  );

  memory_fsm_fib_checker_word_cmp #(.PAT(PAT1)) u_cmp1 (
    .seg      (cmp_seg),
    .q        (mem.q1),
    .mismatch (mis1)
  );

  always_comb begin
    err_sum  = {1'b0, err_count} + {{ERR_W{1'b0}}, mis0} + {{ERR_W{1'b0}}, mis1};
    err_next = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  // Segment counter, compare pipeline and error/first-fail capture.
  always_ff @(posedge clk) begin
    if (clr) begin
      seg        <= '0;
      cmp_valid  <= 1'b0;
      cmp_seg    <= '0;
      err_count  <= '0;
      fail_seg   <= '0;
      fail_port  <= 1'b0;
      first_seen <= 1'b0;
      done       <= 1'b0;
    end else begin
      cmp_valid <= (state == READ);
      done      <= (state == DONE) && !start;
      if (state == READ) begin
        cmp_seg <= seg;
        if (seg != LAST_SEG) seg <= seg + SEG_W'(1);
      end
      if (start_ok) begin
        seg        <= '0;
        err_count  <= '0;
        fail_seg   <= '0;
        fail_port  <= 1'b0;
        first_seen <= 1'b0;
      end else if (cmp_valid) begin
        err_count <= err_next;
        // Port 0 takes precedence when both ports fail in the same cycle.
        if (!first_seen && (mis0 || mis1)) begin
          first_seen <= 1'b1;
          fail_seg   <= cmp_seg;
          fail_port  <= !mis0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_fsm_fib_checker.sv
// Directed bench for memory_fsm_fib_checker: a 1-cycle-latency memory model
// loaded with the writer image, plus corrupted images and reset/start corner cases.
module tb_memory_fsm_fib_checker;
  import memory_fsm_fib_checker_pkg::*;

  logic              clk;
  logic              clr;
  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [SEG_W-1:0]  fail_seg;
  logic              fail_port;
  state_t            dbg_state;

  int checks;
  int errors;
  int addr_bad;
  int wr_bad;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  memory_fsm_fib_checker_if mif ();

  memory_fsm_fib_checker dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .mem       (mif),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_seg  (fail_seg),
    .fail_port (fail_port),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    mif.q0 <= mem[mif.addr0];
    mif.q1 <= mem[mif.addr1];
    if (mif.addr0 > 15'h7BFF || mif.addr1 > 15'h7BFF) addr_bad++;
    if (mif.w0 !== 1'b0 || mif.w1 !== 1'b0) wr_bad++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input bit zero_only);
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    if (!zero_only) begin
      for (int s = 0; s <= 30; s++) begin
        mem[{s[4:0], 10'h000}] = 16'(s * 16 + 10);
        mem[{s[4:0], 10'h3FF}] = 16'(s * 16 + 14);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Start a sweep and count edges until done; optionally pulse start again mid-sweep.
  task automatic run_sweep(input int pulse_at, output int lat,
                           output logic [ADDR_W-1:0] a0_s3, output logic [ADDR_W-1:0] a1_s3,
                           output logic busy_s3);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    a0_s3 = '0;
    a1_s3 = '0;
    busy_s3 = 1'b0;
    while (!done && lat < 100) begin
      if (lat == pulse_at) start = 1'b1;
      tick();
      start = 1'b0;
      lat++;
      if (lat == 3) begin
        a0_s3   = mif.addr0;
        a1_s3   = mif.addr1;
        busy_s3 = busy;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic b3;

    checks = 0; errors = 0; addr_bad = 0; wr_bad = 0;
    clr = 1'b1; start = 1'b0;
    load_image(1'b0);
    repeat (3) tick();
    clr = 1'b0;
    tick();

    chk("rst_state",     32'(dbg_state), 32'(IDLE));
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_pass",      32'(pass),      32'd0);
    chk("rst_err",       32'(err_count), 32'd0);
    chk("rst_fail_seg",  32'(fail_seg),  32'd0);
    chk("rst_fail_port", 32'(fail_port), 32'd0);
    chk("rst_addr0",     32'(mif.addr0), 32'd0);
    chk("rst_addr1",     32'(mif.addr1), 32'd0);

    // Clean image
    run_sweep(-1, lat, a0, a1, b3);
    chk("clean_latency", 32'(lat),       32'd33);
    chk("clean_done",    32'(done),      32'd1);
    chk("clean_pass",    32'(pass),      32'd1);
    chk("clean_err",     32'(err_count), 32'd0);
    chk("seg3_addr0",    32'(a0),        32'h0C00);
    chk("seg3_addr1",    32'(a1),        32'h0FFF);
    chk("seg3_busy",     32'(b3),        32'd1);
    chk("done_addr1",    32'(mif.addr1), 32'h7BFF);

    // Seg 7 port 1 corrupted
    mem[{5'd7, 10'h3FF}] = 16'h007F;
    run_sweep(-1, lat, a0, a1, b3);
    chk("s7_latency",  32'(lat),       32'd33);
    chk("s7_err",      32'(err_count), 32'd1);
    chk("s7_fail_seg", 32'(fail_seg),  32'd7);
    chk("s7_port",     32'(fail_port), 32'd1);
    chk("s7_pass",     32'(pass),      32'd0);

    // Restart from DONE: done drops and the count restarts from zero
    load_image(1'b0);
    mem[{5'd0,  10'h000}] = 16'h000B;
    mem[{5'd0,  10'h3FF}] = 16'h000F;
    mem[{5'd30, 10'h000}] = 16'h01EB;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", 32'(done),      32'd0);
    chk("restart_err",  32'(err_count), 32'd0);
    chk("restart_busy", 32'(busy),      32'd1);
    lat = 0;
    while (!done && lat < 100) begin tick(); lat++; end
    chk("multi_latency", 32'(lat),       32'd33);
    chk("multi_err",     32'(err_count), 32'd3);
    chk("multi_seg",     32'(fail_seg),  32'd0);
    chk("multi_port",    32'(fail_port), 32'd0);
    chk("multi_pass",    32'(pass),      32'd0);

    // All-zero memory
    load_image(1'b1);
    run_sweep(-1, lat, a0, a1, b3);
    chk("zero_err",  32'(err_count), 32'd62);
    chk("zero_seg",  32'(fail_seg),  32'd0);
    chk("zero_port", 32'(fail_port), 32'd0);
    chk("zero_pass", 32'(pass),      32'd0);

    // clr ten cycles into a sweep on a failing image
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("mid_err_nonzero", 32'(err_count != 0), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy",  32'(busy),      32'd0);
    chk("clr_addr0", 32'(mif.addr0), 32'd0);
    chk("clr_err",   32'(err_count), 32'd0);
    chk("clr_state", 32'(dbg_state), 32'(IDLE));
    tick();
    chk("clr_still_idle", 32'(dbg_state), 32'(IDLE));
    load_image(1'b0);
    run_sweep(-1, lat, a0, a1, b3);
    chk("post_clr_latency", 32'(lat),  32'd33);
    chk("post_clr_pass",    32'(pass), 32'd1);

    // start pulsed while busy does not disturb timing
    run_sweep(5, lat, a0, a1, b3);
    chk("busy_start_latency", 32'(lat),       32'd33);
    chk("busy_start_pass",    32'(pass),      32'd1);

    // start and clr together from DONE: clr wins
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    chk("clr_start_state", 32'(dbg_state), 32'(IDLE));
    chk("clr_start_busy",  32'(busy),      32'd0);
    chk("clr_start_done",  32'(done),      32'd0);

    chk("addr_bound", 32'(addr_bad), 32'd0);
    chk("no_writes",  32'(wr_bad),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
